// File: rtl/regfile_arbiter.sv
// regfile_arbiter: sequences accesses to a 16x8 register file port and
// shares that port between requester A (decoder) and B (debug/loader).
// Ports: clk; reset (async, active-low); a_/b_ req, we, addr, wdata in;
//   a_/b_ ack (1-cycle pulse) and rdata (last read) out; rf_load, rf_dump,
//   rf_regnum, rf_wdata to the register file; rf_rdata from it; busy.
// Build option: REGARB_FIXED_PRIO_EN gives A fixed priority over B;
//   when undefined, simultaneous requests are served round-robin.
module regfile_arbiter #(
   parameter int ADDR_W   = 4,
   parameter int DATA_W   = 8,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic              rf_load,
   output logic              rf_dump,
   output logic [ADDR_W-1:0] rf_regnum,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      WR,
      RD,
      RESP
   } state_t;

   localparam logic [1:0] LAST = 2'(READ_LAT - 1);

   state_t     r_state;
   state_t     w_next;
   logic       r_win;
   logic [1:0] r_cnt;
   logic       w_grant;
   logic       w_pick_b;
   logic       w_we;
   logic       w_rd_done;

   assign w_grant = a_req | b_req;

`ifdef REGARB_FIXED_PRIO_EN
   assign w_pick_b = ~a_req;
`else
   // r_ptr: 0 prefers A, 1 prefers B on a tie.
   logic r_ptr;

   assign w_pick_b = b_req & (~a_req | r_ptr);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr <= 1'b0;
      end else if (r_state == RESP) begin
         r_ptr <= ~r_win;
      end
   end
`endif

   assign w_we      = w_pick_b ? b_we : a_we;
   assign w_rd_done = (r_state == RD) && (r_cnt == LAST);

   // Pins decode straight from state so an async reset drops them at once.
   always_comb begin
      w_next  = r_state;
      rf_load = 1'b0;
      rf_dump = 1'b0;
      a_ack   = 1'b0;
      b_ack   = 1'b0;
      busy    = 1'b1;
      unique case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (w_grant) begin
               w_next = w_we ? WR : RD;
            end
         end
         WR: begin
            rf_load = 1'b1;
            w_next  = RESP;
         end
         RD: begin
            rf_dump = 1'b1;
            if (r_cnt == LAST) begin
               w_next = RESP;
            end
         end
         RESP: begin
            a_ack  = ~r_win;
            b_ack  = r_win;
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_win     <= 1'b0;
         r_cnt     <= '0;
         rf_regnum <= '0;
         rf_wdata  <= '0;
         a_rdata   <= '0;
         b_rdata   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_grant) begin
            r_win     <= w_pick_b;
            rf_regnum <= w_pick_b ? b_addr : a_addr;
            if (w_we) begin
               rf_wdata <= w_pick_b ? b_wdata : a_wdata;
            end
         end
         if (r_state == RD) begin
            r_cnt <= (r_cnt == LAST) ? 2'd0 : r_cnt + 2'd1;
         end
         if (w_rd_done) begin
            if (r_win) begin
               b_rdata <= rf_rdata;
            end else begin
               a_rdata <= rf_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: randomized bench for regfile_arbiter with a
// transaction-level model of grants, latencies and register contents.
module tb_regfile_arbiter;

   localparam int RL = 2;
`ifdef REGARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   typedef struct {
      bit         on;
      bit         we;
      logic [3:0] addr;
      logic [7:0] data;
   } rq_t;

   logic       clk;
   logic       reset;
   logic       a_req, a_we, a_ack;
   logic [3:0] a_addr;
   logic [7:0] a_wdata, a_rdata;
   logic       b_req, b_we, b_ack;
   logic [3:0] b_addr;
   logic [7:0] b_wdata, b_rdata;
   logic       rf_load, rf_dump, busy;
   logic [3:0] rf_regnum;
   logic [7:0] rf_wdata, rf_rdata;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int ptr   = 0;

   rq_t        rq [2];
   logic [7:0] rdm [2];
   logic [7:0] exp_mem [16];
   logic [7:0] rf_mem [16];

   regfile_arbiter #(
      .ADDR_W   (4),
      .DATA_W   (8),
      .READ_LAT (RL)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .a_req     (a_req),
      .a_we      (a_we),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .a_ack     (a_ack),
      .a_rdata   (a_rdata),
      .b_req     (b_req),
      .b_we      (b_we),
      .b_addr    (b_addr),
      .b_wdata   (b_wdata),
      .b_ack     (b_ack),
      .b_rdata   (b_rdata),
      .rf_load   (rf_load),
      .rf_dump   (rf_dump),
      .rf_regnum (rf_regnum),
      .rf_wdata  (rf_wdata),
      .rf_rdata  (rf_rdata),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (rf_load) rf_mem[rf_regnum] <= rf_wdata;
   assign rf_rdata = rf_dump ? rf_mem[rf_regnum] : 8'h00;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int lat(input bit we);
      return we ? 2 : 1 + RL;
   endfunction

   function automatic logic ackof(input int w);
      return (w != 0) ? b_ack : a_ack;
   endfunction

   function automatic logic [7:0] rdof(input int w);
      return (w != 0) ? b_rdata : a_rdata;
   endfunction

   task automatic apply();
      a_req   = rq[0].on;
      a_we    = rq[0].we;
      a_addr  = rq[0].addr;
      a_wdata = rq[0].data;
      b_req   = rq[1].on;
      b_we    = rq[1].we;
      b_addr  = rq[1].addr;
      b_wdata = rq[1].data;
   endtask

   task automatic set_rq(input int w, input bit on, input bit we,
                         input logic [3:0] ad, input logic [7:0] d);
      rq[w].on   = on;
      rq[w].we   = we;
      rq[w].addr = ad;
      rq[w].data = d;
   endtask

   // Entry/exit: #1 after a rising edge, DUT idle in this cycle.
   task automatic run_round();
      int p, w1, w2, cur, loads, dumps, el, ed;
      int ea [2];
      bit done [2];
      p = cyc;
      apply();
      if (rq[0].on && rq[1].on) begin
         w1 = FIXED ? 0 : ptr;
         w2 = 1 - w1;
      end else begin
         w1 = rq[0].on ? 0 : 1;
         w2 = -1;
      end
      ea[0] = 0;
      ea[1] = 0;
      ea[w1] = p + lat(rq[w1].we);
      if (w2 >= 0) ea[w2] = ea[w1] + 1 + lat(rq[w2].we);
      el = 0;
      ed = 0;
      for (int w = 0; w < 2; w++) begin
         if (rq[w].on) begin
            if (rq[w].we) el++;
            else ed += RL;
         end
      end
      cur = w1;
      loads = 0;
      dumps = 0;
      done[0] = 1'b0;
      done[1] = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         chk("ld_dp_excl", 32'(rf_load & rf_dump), 0);
         if (rf_load) begin
            loads++;
            chk("ld_addr", 32'(rf_regnum), 32'(rq[cur].addr));
            chk("ld_data", 32'(rf_wdata), 32'(rq[cur].data));
         end
         if (rf_dump) begin
            dumps++;
            chk("dp_addr", 32'(rf_regnum), 32'(rq[cur].addr));
         end
         for (int w = 0; w < 2; w++) begin
            if (ackof(w)) begin
               chk("ack_owner", 32'(rq[w].on & ~done[w]), 1);
               chk((w != 0) ? "b_ack_cyc" : "a_ack_cyc", cyc, ea[w]);
               if (rq[w].we) exp_mem[rq[w].addr] = rq[w].data;
               else rdm[w] = exp_mem[rq[w].addr];
               chk((w != 0) ? "b_rdata" : "a_rdata", 32'(rdof(w)), 32'(rdm[w]));
               chk((w != 0) ? "a_rdata_hold" : "b_rdata_hold",
                   32'(rdof(1 - w)), 32'(rdm[1 - w]));
               ptr = 1 - w;
               done[w] = 1'b1;
               cur = 1 - w;
            end
         end
         @(posedge clk);
         #1;
         if (done[0]) a_req = 1'b0;
         if (done[1]) b_req = 1'b0;
         if ((done[0] || !rq[0].on) && (done[1] || !rq[1].on)) break;
      end
      chk("round_done", {30'd0, done[1], done[0]}, {30'd0, rq[1].on, rq[0].on});
      chk("load_cycles", loads, el);
      chk("dump_cycles", dumps, ed);
      a_req = 1'b0;
      b_req = 1'b0;
      rq[0].on = 1'b0;
      rq[1].on = 1'b0;
   endtask

   // Both requesters keep read requests up for n grants.
   task automatic hold_both(input int n);
      int nxt, got, w, expw;
      set_rq(0, 1'b1, 1'b0, 4'($urandom), 8'h00);
      set_rq(1, 1'b1, 1'b0, 4'($urandom), 8'h00);
      apply();
      nxt = cyc + 1 + RL;
      got = 0;
      for (int i = 0; i < 200 && got < n; i++) begin
         @(negedge clk);
         if (a_ack || b_ack) begin
            w = b_ack ? 1 : 0;
            expw = FIXED ? 0 : ptr;
            chk("g_who", w, expw);
            chk("g_cyc", cyc, nxt);
            chk("g_ack_excl", 32'(a_ack & b_ack), 0);
            rdm[w] = exp_mem[rq[w].addr];
            chk("g_rdata", 32'(rdof(w)), 32'(rdm[w]));
            ptr = 1 - w;
            nxt += 2 + RL;
            got++;
         end
         @(posedge clk);
         #1;
      end
      chk("g_count", got, n);
      a_req = 1'b0;
      b_req = 1'b0;
      rq[0].on = 1'b0;
      rq[1].on = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         rf_mem[i]  = 8'h00;
         exp_mem[i] = 8'h00;
      end
      rdm[0] = 8'h00;
      rdm[1] = 8'h00;
      set_rq(0, 1'b0, 1'b0, 4'd0, 8'h00);
      set_rq(1, 1'b0, 1'b0, 4'd0, 8'h00);
      apply();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_a_ack", 32'(a_ack), 0);
      chk("rst_b_ack", 32'(b_ack), 0);
      chk("rst_a_rdata", 32'(a_rdata), 0);
      chk("rst_b_rdata", 32'(b_rdata), 0);
      chk("rst_load", 32'(rf_load), 0);
      chk("rst_dump", 32'(rf_dump), 0);
      chk("rst_regnum", 32'(rf_regnum), 0);
      chk("rst_wdata", 32'(rf_wdata), 0);
      chk("rst_busy", 32'(busy), 0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      set_rq(0, 1'b1, 1'b1, 4'd1, 8'hCC);
      run_round();
      set_rq(0, 1'b1, 1'b0, 4'd1, 8'h00);
      run_round();
      set_rq(1, 1'b1, 1'b0, 4'd0, 8'h00);
      run_round();
      set_rq(0, 1'b1, 1'b1, 4'd1, 8'h11);
      set_rq(1, 1'b1, 1'b1, 4'd15, 8'hF0);
      run_round();
      set_rq(1, 1'b1, 1'b0, 4'd15, 8'h00);
      run_round();
      set_rq(0, 1'b1, 1'b0, 4'd1, 8'h00);
      run_round();

      hold_both(6);

      for (int r = 0; r < 40; r++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         for (int w = 0; w < 2; w++) begin
            set_rq(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom), 8'($urandom));
         end
         if (!rq[0].on && !rq[1].on) rq[$urandom_range(0, 1)].on = 1'b1;
         run_round();
      end

      // Abort a read mid-dump; pointer is left at B beforehand.
      set_rq(0, 1'b1, 1'b1, 4'd3, 8'h5A);
      run_round();
      set_rq(0, 1'b1, 1'b0, 4'd3, 8'h00);
      apply();
      @(posedge clk);
      #1;
      chk("abort_dump1", 32'(rf_dump), 1);
      @(posedge clk);
      #2;
      chk("abort_dump2", 32'(rf_dump), 1);
      reset = 1'b0;
      #1;
      chk("abort_dump_drop", 32'(rf_dump), 0);
      chk("abort_load", 32'(rf_load), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_ack", 32'(a_ack | b_ack), 0);
      a_req = 1'b0;
      rq[0].on = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("abort_no_ack", 32'(a_ack | b_ack), 0);
      end
      chk("abort_a_rdata", 32'(a_rdata), 0);
      chk("abort_b_rdata", 32'(b_rdata), 0);
      reset = 1'b1;
      ptr = 0;
      rdm[0] = 8'h00;
      rdm[1] = 8'h00;
      @(posedge clk);
      #1;
      chk("post_rst_busy", 32'(busy), 0);
      set_rq(0, 1'b1, 1'b1, 4'd2, 8'h3C);
      set_rq(1, 1'b1, 1'b1, 4'd4, 8'hC3);
      run_round();
      set_rq(1, 1'b1, 1'b0, 4'd2, 8'h00);
      run_round();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Sequences every access to the 16x8 RegisterFile and shares its single load/dump port between two requesters.
- Requester A is the instruction decoder. Requester B is the debug/loader port.
- Each request is a write or a read. The arbiter grants one request at a time, drives the register-file control pins, and returns an ack with read data.

Parameters:
- ADDR_W, 4, register number width; matches the RegisterFile RegNumber port.
- DATA_W, 8, data width.
- READ_LAT, 1, cycles DumpReg is held before out is captured; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_req  in  1  requester A access request.
- a_we  in  1  A: 1=write, 0=read.
- a_addr  in  ADDR_W  A register number.
- a_wdata  in  DATA_W  A write data.
- a_ack  out  1  A one-cycle completion pulse.
- a_rdata  out  DATA_W  A last read data.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  (same directions and widths as A)  requester B.
- rf_load  out  1  to RegisterFile LoadReg.
- rf_dump  out  1  to RegisterFile DumpReg.
- rf_regnum  out  ADDR_W  to RegisterFile RegNumber.
- rf_wdata  out  DATA_W  to RegisterFile in.
- rf_rdata  in  DATA_W  from RegisterFile out.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, WR, RD, RESP. Reset state is IDLE.
- Reset values (reset=0, asynchronous): all outputs 0; a_rdata and b_rdata 0; round-robin pointer = A; read counter 0.
- Reset mid-operation aborts the access. No ack is issued; rf_load and rf_dump drop immediately.
- IDLE: requests are sampled only on the rising edge that ends an IDLE cycle.
  - No request: stay in IDLE.
  - One request: that requester wins.
  - Both requesting: the pointer's requester wins.
  - The winner's we, addr and wdata are latched into rf_regnum and rf_wdata. rf_wdata is latched only for writes.
  - Next state is WR if we=1, else RD.
- WR: rf_load=1 for exactly one cycle, rf_regnum and rf_wdata stable. Next state RESP.
- RD: rf_dump=1 for exactly READ_LAT cycles. A counter runs 0..READ_LAT-1. On the edge ending the last RD cycle, rf_rdata is captured into the winner's rdata register. Next state RESP.
- RESP: the winner's ack=1 for one cycle. The pointer then points to the other requester. Next state IDLE.
- Latency, with req sampled on edge N:
  - Write: ack high during cycle N+2.
  - Read: ack high during cycle N+1+READ_LAT; rdata valid from the same cycle.
- rdata holds its value until that requester's next completed read. Writes never change rdata.
- Requester rules:
  - Hold req, we, addr and wdata stable from assertion until ack.
  - Drop req on the edge that ends the ack cycle.
  - A req still high in the following IDLE cycle is a new request.
  - A loser keeps req high and is served on its next turn.
- rf_load and rf_dump are never high together. Both are 0 in IDLE and RESP.
- Minimum spacing between back-to-back grants is 3 cycles (write) and 2+READ_LAT cycles (read), because one IDLE cycle always separates accesses.
- A write to register 15 or a read of register 0 has no special handling. All 16 registers are accessed identically.

Optional Feature:
- Macro: REGARB_FIXED_PRIO_EN.
- Defined: requester A always wins a simultaneous request, and the pointer is unused. B can starve under continuous A traffic; this is accepted for debug use.
- Undefined: round-robin as described above, and neither requester waits more than one foreign access.

Test Plan:
- Reset, then A write addr=1 wdata=0xCC: rf_load high exactly one cycle with rf_regnum=1 and rf_wdata=0xCC; a_ack two cycles after the sampling edge; b_ack stays 0.
- A read addr=1 after the write above (READ_LAT=1, register file holds 0xCC): rf_dump high one cycle; a_ack with a_rdata=0xCC; b_rdata unchanged at 0.
- A write addr=1 0x11 and B write addr=15 0xF0 requested in the same cycle, round-robin, pointer at A: A is served first, then B; acks 3 cycles apart; register file ends with 1=0x11 and 15=0xF0.
- Both requesters hold read requests continuously for 6 grants: grants alternate A,B,A,B,A,B. With REGARB_FIXED_PRIO_EN defined, all 6 grants go to A.
- reset driven low during RD with READ_LAT=3, on the second dump cycle: rf_dump drops asynchronously; no ack; busy=0; state IDLE; pointer=A after release.
- READ_LAT=2, B read addr=15: rf_dump high for exactly 2 cycles; b_ack one cycle after dump falls; b_rdata equals stored 0xF0.
